// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-rate counters, composer strobes and
// pipeline-aligned VGA sync / data-enable outputs.
module video_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int OUT_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       interlaced,
  output logic       display_next_pixel,
  output logic       display_next_line,
  output logic       display_next_frame,
  output logic       display_current_field,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DLY_W   = (OUT_DELAY > 0) ? OUT_DELAY : 1;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
      $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV != 1 && CLK_DIV != 2) begin : g_bad_clk_div
      $error("video_timing_gen: CLK_DIV must be 1 or 2");
    end
  endgenerate

  logic                  div_q, div_d;
  logic [9:0]            h_q, h_d, v_q, v_d;
  logic                  field_q, field_d;
  logic                  pixel_q, pixel_d, line_q, line_d, frame_q, frame_d;
  logic [DLY_W-1:0][2:0] dly_q, dly_d;
  logic                  hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic                  pix_en_s, step_s;
  logic [10:0]           h_ext_s, v_ext_s;
  logic [2:0]            raw_s, tail_s;

  always_comb begin
    pix_en_s = (CLK_DIV == 1) ? 1'b1 : div_q;
    step_s   = pix_en_s & enable;
    div_d    = enable ? ~div_q : div_q;
  end

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    field_d = field_q;
    if (step_s) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) begin
          v_d     = 10'd0;
          field_d = interlaced ? ~field_q : 1'b0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Strobes describe the position being left, so the composer sees them while the counter has moved on.
  always_comb begin
    pixel_d = pixel_q;
    line_d  = line_q;
    frame_d = frame_q;
    if (!enable) begin
      pixel_d = 1'b0;
      line_d  = 1'b0;
      frame_d = 1'b0;
    end else if (pix_en_s) begin
      pixel_d = ({1'b0, h_q} < H_ACT);
      line_d  = (h_q == H_LAST);
      frame_d = (h_q == H_LAST) && (v_q == V_LAST);
    end
  end

  // Delay line carries active-high flags {hs, vs, de}; polarity is applied only at the pins.
  always_comb begin
    h_ext_s = {1'b0, h_q};
    v_ext_s = {1'b0, v_q};
    raw_s   = {(h_ext_s >= HS_BEG) && (h_ext_s < HS_END),
               (v_ext_s >= VS_BEG) && (v_ext_s < VS_END),
               (h_ext_s < H_ACT) && (v_ext_s < V_ACT)};
    if (!enable) begin
      raw_s = 3'b000;
    end
    dly_d = dly_q;
    if (pix_en_s) begin
      dly_d[0] = raw_s;
      for (int i = 1; i < DLY_W; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end
    tail_s = (OUT_DELAY > 0) ? dly_q[DLY_W-1] : raw_s;
    hs_d   = hs_q;
    vs_d   = vs_q;
    de_d   = de_q;
    if (pix_en_s) begin
      hs_d = (tail_s[2] && enable) ? SYNC_POL : ~SYNC_POL;
      vs_d = (tail_s[1] && enable) ? SYNC_POL : ~SYNC_POL;
      de_d = tail_s[0] && enable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= 1'b0;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      field_q <= 1'b0;
      pixel_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      dly_q   <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      de_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      field_q <= field_d;
      pixel_q <= pixel_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      dly_q   <= dly_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
    end
  end

  assign display_next_pixel    = pixel_q;
  assign display_next_line     = line_q;
  assign display_next_frame    = frame_q;
  assign display_current_field = field_q;
  assign h_count               = h_q;
  assign v_count               = v_q;
  assign vga_hsync             = hs_q;
  assign vga_vsync             = vs_q;
  assign vga_de                = de_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a small raster so whole frames fit in a short run.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = 2 * HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, il_a, px_a, ln_a, fr_a, fld_a, hs_a, vs_a, de_a;
  logic rst_b, en_b, il_b, px_b, ln_b, fr_b, fld_b, hs_b, vs_b, de_b;
  logic [9:0] h_a, v_a, h_b, v_b;

  video_timing_gen #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .SYNC_POL(1'b0), .OUT_DELAY(2)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .interlaced(il_a),
    .display_next_pixel(px_a), .display_next_line(ln_a), .display_next_frame(fr_a),
    .display_current_field(fld_a), .h_count(h_a), .v_count(v_a),
    .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_de(de_a));

  video_timing_gen #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .SYNC_POL(1'b1), .OUT_DELAY(0)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .interlaced(il_b),
    .display_next_pixel(px_b), .display_next_line(ln_b), .display_next_frame(fr_b),
    .display_current_field(fld_b), .h_count(h_b), .v_count(v_b),
    .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_de(de_b));

  int vec = 0;
  int errs = 0;

  // Reference model for dut_a: m_n counts pixels advanced since reset; position is m_n mod the raster.
  int m_n, m_ec, vga_from;
  bit m_px, m_ln, m_fr, m_fld, m_paused;

  function automatic logic [2:0] raw_of(int p);
    int h, v;
    if (p < 0) return 3'b000;
    h = p % HT;
    v = (p / HT) % VT;
    return {h >= HA + HF && h < HA + HF + HS, v >= VA + VF && v < VA + VF + VS, h < HA && v < VA};
  endfunction

  task automatic model_clear();
    m_n = 0; m_ec = 0; vga_from = 0; m_paused = 1'b0;
    m_px = 1'b0; m_ln = 1'b0; m_fr = 1'b0; m_fld = 1'b0;
  endtask

  task automatic step_a();
    bit tick;
    int ph, pv;
    @(posedge clk);
    tick = 1'b0;
    if (en_a) begin
      if (m_paused) begin
        vga_from = m_n;
        m_paused = 1'b0;
      end
      m_ec++;
      tick = (m_ec % 2 == 0);
    end else begin
      m_paused = 1'b1;
    end
    if (!en_a) begin
      m_px = 1'b0; m_ln = 1'b0; m_fr = 1'b0;
    end else if (tick) begin
      ph = m_n % HT;
      pv = (m_n / HT) % VT;
      m_px = (ph < HA);
      m_ln = (ph == HT - 1);
      m_fr = m_ln && (pv == VT - 1);
      if (m_fr) m_fld = il_a ? ~m_fld : 1'b0;
      m_n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; en_a = 1'b1; il_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b1; il_b = 1'b0;
    model_clear();
    #12;
    vec++; if ({h_a, v_a} !== 20'd0) begin errs++; $display("FAIL reset_cnt_a: got %0d/%0d want 0/0", h_a, v_a); end
    vec++; if ({px_a, ln_a, fr_a, fld_a} !== 4'b0000) begin errs++; $display("FAIL reset_strobe_a: got %b want 0000", {px_a, ln_a, fr_a, fld_a}); end
    vec++; if ({hs_a, vs_a, de_a} !== 3'b110) begin errs++; $display("FAIL reset_vga_a: got %b want 110", {hs_a, vs_a, de_a}); end
    vec++; if ({h_b, v_b} !== 20'd0) begin errs++; $display("FAIL reset_cnt_b: got %0d/%0d want 0/0", h_b, v_b); end
    vec++; if ({px_b, ln_b, fr_b, fld_b} !== 4'b0000) begin errs++; $display("FAIL reset_strobe_b: got %b want 0000", {px_b, ln_b, fr_b, fld_b}); end
    vec++; if ({hs_b, vs_b, de_b} !== 3'b000) begin errs++; $display("FAIL reset_vga_b: got %b want 000", {hs_b, vs_b, de_b}); end
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_line_frame();
    int lines = 0, frames = 0;
    bit pl = 1'b0, pf = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      step_a();
      vec++; if (h_a !== 10'(m_n % HT) || v_a !== 10'((m_n / HT) % VT)) begin errs++; $display("FAIL count: got %0d/%0d want %0d/%0d", h_a, v_a, m_n % HT, (m_n / HT) % VT); end
      vec++; if ({px_a, ln_a, fr_a} !== {m_px, m_ln, m_fr}) begin errs++; $display("FAIL strobes: got %b want %b", {px_a, ln_a, fr_a}, {m_px, m_ln, m_fr}); end
      vec++; if (fr_a && !ln_a) begin errs++; $display("FAIL frame_vs_line: got frame=1 line=0 want line=1"); end
      if (ln_a && !pl) lines++;
      if (fr_a && !pf) frames++;
      pl = ln_a; pf = fr_a;
    end
    vec++; if (lines != 2 * VT) begin errs++; $display("FAIL line_count: got %0d want %0d", lines, 2 * VT); end
    vec++; if (frames != 2) begin errs++; $display("FAIL frame_count: got %0d want 2", frames); end
  endtask

  task automatic test_sync();
    int de_n = 0, hs_n = 0, vs_n = 0;
    logic [2:0] r;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step_a();
      r = raw_of(m_n - 3);
      vec++; if ({hs_a, vs_a, de_a} !== {~r[2], ~r[1], r[0]}) begin errs++; $display("FAIL sync_out: n=%0d got %b want %b", m_n, {hs_a, vs_a, de_a}, {~r[2], ~r[1], r[0]}); end
      de_n += int'(de_a); hs_n += int'(!hs_a); vs_n += int'(!vs_a);
    end
    vec++; if (de_n != 2 * HA * VA) begin errs++; $display("FAIL de_clks: got %0d want %0d", de_n, 2 * HA * VA); end
    vec++; if (hs_n != 2 * HS * VT) begin errs++; $display("FAIL hsync_clks: got %0d want %0d", hs_n, 2 * HS * VT); end
    vec++; if (vs_n != 2 * VS * HT) begin errs++; $display("FAIL vsync_clks: got %0d want %0d", vs_n, 2 * VS * HT); end
  endtask

  task automatic test_interlace();
    int toggles = 0;
    bit pv;
    il_a = 1'b1;
    pv = fld_a;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      step_a();
      vec++; if (fld_a !== m_fld) begin errs++; $display("FAIL field_il: got %b want %b", fld_a, m_fld); end
      if (fld_a != pv) toggles++;
      pv = fld_a;
    end
    vec++; if (toggles != 3 || fld_a !== 1'b1) begin errs++; $display("FAIL field_toggles: got %0d/%b want 3/1", toggles, fld_a); end
    il_a = 1'b0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step_a();
      vec++; if (fld_a !== m_fld) begin errs++; $display("FAIL field_prog: got %b want %b", fld_a, m_fld); end
    end
    vec++; if (fld_a !== 1'b0) begin errs++; $display("FAIL field_clear: got %b want 0", fld_a); end
  endtask

  task automatic test_pause();
    for (int it = 0; it < 3; it++) begin
      int pos, hold, n_res, steps;
      bit seen, pl;
      pos  = $urandom_range(1, HT - 2);
      hold = $urandom_range(20, 60);
      steps = 0;
      while ((m_n % HT) != pos && steps < 2 * FRAME_CLKS) begin step_a(); steps++; end
      en_a = 1'b0;
      for (int i = 0; i < hold; i++) begin
        step_a();
        vec++; if (h_a !== 10'(pos)) begin errs++; $display("FAIL pause_h: got %0d want %0d", h_a, pos); end
        vec++; if ({px_a, ln_a, fr_a} !== 3'b000) begin errs++; $display("FAIL pause_strobes: got %b want 000", {px_a, ln_a, fr_a}); end
      end
      en_a = 1'b1;
      n_res = m_n;
      seen = 1'b0; pl = ln_a;
      for (int i = 0; i < 4 * HT + 4 && !seen; i++) begin
        step_a();
        vec++; if (h_a !== 10'(m_n % HT) || {px_a, ln_a} !== {m_px, m_ln}) begin errs++; $display("FAIL resume: got h=%0d %b want h=%0d %b", h_a, {px_a, ln_a}, m_n % HT, {m_px, m_ln}); end
        if (ln_a && !pl) begin
          seen = 1'b1;
          vec++; if (m_n - n_res != HT - pos) begin errs++; $display("FAIL resume_len: got %0d want %0d", m_n - n_res, HT - pos); end
        end
        pl = ln_a;
      end
      vec++; if (!seen) begin errs++; $display("FAIL resume_timeout: got no line strobe want one"); end
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    int p;
    for (int i = 0; i < 800; i++) begin
      en_a = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) il_a = ~il_a;
      step_a();
      vec++; if (h_a !== 10'(m_n % HT) || v_a !== 10'((m_n / HT) % VT)) begin errs++; $display("FAIL rnd_count: got %0d/%0d want %0d/%0d", h_a, v_a, m_n % HT, (m_n / HT) % VT); end
      vec++; if ({px_a, ln_a, fr_a, fld_a} !== {m_px, m_ln, m_fr, m_fld}) begin errs++; $display("FAIL rnd_strobes: got %b want %b", {px_a, ln_a, fr_a, fld_a}, {m_px, m_ln, m_fr, m_fld}); end
      p = m_n - 3;
      if (!m_paused && p >= vga_from) begin
        r = raw_of(p);
        vec++; if ({hs_a, vs_a, de_a} !== {~r[2], ~r[1], r[0]}) begin errs++; $display("FAIL rnd_vga: got %b want %b", {hs_a, vs_a, de_a}, {~r[2], ~r[1], r[0]}); end
      end
    end
    en_a = 1'b1;
  endtask

  task automatic test_clkdiv1_reset();
    int target, steps;
    logic [2:0] r;
    target = $urandom_range(5, 15);
    steps = 0;
    while (h_b != 10'(target) && steps < 4 * HT) begin @(negedge clk); steps++; end
    vec++; if (h_b !== 10'(target)) begin errs++; $display("FAIL b_sync_timeout: got %0d want %0d", h_b, target); end
    #2 rst_b = 1'b1;
    #1;
    vec++; if ({h_b, v_b} !== 20'd0) begin errs++; $display("FAIL b_rst_cnt: got %0d/%0d want 0/0", h_b, v_b); end
    vec++; if ({px_b, ln_b, fr_b, fld_b, hs_b, vs_b, de_b} !== 7'd0) begin errs++; $display("FAIL b_rst_out: got %b want 0000000", {px_b, ln_b, fr_b, fld_b, hs_b, vs_b, de_b}); end
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 1; k <= HT + 2; k++) begin
      @(negedge clk);
      r = raw_of(k - 1);
      vec++; if (h_b !== 10'(k % HT)) begin errs++; $display("FAIL b_h: k=%0d got %0d want %0d", k, h_b, k % HT); end
      vec++; if (ln_b !== (k == HT)) begin errs++; $display("FAIL b_line: k=%0d got %b want %b", k, ln_b, k == HT); end
      vec++; if (px_b !== ((k - 1) % HT < HA)) begin errs++; $display("FAIL b_pixel: k=%0d got %b want %b", k, px_b, (k - 1) % HT < HA); end
      vec++; if ({hs_b, vs_b, de_b} !== r) begin errs++; $display("FAIL b_vga: k=%0d got %b want %b", k, {hs_b, vs_b, de_b}, r); end
    end
  endtask

  initial begin
    test_reset();
    test_line_frame();
    test_sync();
    test_interlace();
    test_pause();
    test_random();
    test_clkdiv1_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
